// File: rtl/kanagawa_hal_fifo_stream_reader_if.sv
// Stream-reader bundle: show-ahead FIFO consumer side (empty/rden/data) plus valid/ready output stream.
// slave = the reader block, master = the environment that drives the FIFO and consumer sides.
interface kanagawa_hal_fifo_stream_reader_if #(
  parameter int WIDTH = 32
);
  logic             empty_in;
  logic             rden_out;
  logic [WIDTH-1:0] data_in;
  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] data_out;
  logic [1:0]       occupancy_out;

  modport slave (
    input  empty_in, data_in, ready_in,
    output rden_out, valid_out, data_out, occupancy_out
  );

  modport master (
    output empty_in, data_in, ready_in,
    input  rden_out, valid_out, data_out, occupancy_out
  );
endinterface

// File: rtl/kanagawa_hal_fifo_stream_reader.sv
// Pops a show-ahead FIFO into a 2-entry buffer and serves it as a registered valid/ready stream;
// rden_out never depends on ready_in. Optional counters under KANAGAWA_FIFO_READER_STATS_EN.
module kanagawa_hal_fifo_stream_reader #(
  parameter int WIDTH       = 32,
  parameter int STATS_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  kanagawa_hal_fifo_stream_reader_if.slave bus
`ifdef KANAGAWA_FIFO_READER_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] xfer_count_out,
  output logic [STATS_WIDTH-1:0] stall_count_out
`endif
);

  if (WIDTH < 1 || STATS_WIDTH < 1) begin : g_bad_param
    $error("kanagawa_hal_fifo_stream_reader: WIDTH and STATS_WIDTH must be >= 1");
  end

  logic [1:0]       count_q, count_d, count_after_pop;
  logic             valid_q;
  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic             push;
  logic             pop;

  assign pop  = valid_q && bus.ready_in;
  // Only local state gates the pop, keeping consumer timing off the FIFO read path.
  assign push = !rst && !bus.empty_in && (count_q < 2'd2);

  always_comb begin
    count_after_pop = count_q - {1'b0, pop};
    slot0_d         = pop ? slot1_q : slot0_q;
    slot1_d         = slot1_q;
    if (push) begin
      if (count_after_pop == 2'd0) begin
        slot0_d = bus.data_in;
      end else begin
        slot1_d = bus.data_in;
      end
    end
    count_d = count_after_pop + {1'b0, push};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
      valid_q <= 1'b0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      count_q <= count_d;
      valid_q <= (count_d != 2'd0);
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign bus.rden_out      = push;
  assign bus.valid_out     = valid_q;
  assign bus.data_out      = slot0_q;
  assign bus.occupancy_out = count_q;

`ifdef KANAGAWA_FIFO_READER_STATS_EN
  logic [STATS_WIDTH-1:0] xfer_q, xfer_d;
  logic [STATS_WIDTH-1:0] stall_q, stall_d;

  always_comb begin
    xfer_d  = xfer_q;
    stall_d = stall_q;
    if (pop && (xfer_q != {STATS_WIDTH{1'b1}})) begin
      xfer_d = xfer_q + 1'b1;
    end
    if (valid_q && !bus.ready_in && (stall_q != {STATS_WIDTH{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_q  <= '0;
      stall_q <= '0;
    end else begin
      xfer_q  <= xfer_d;
      stall_q <= stall_d;
    end
  end

  assign xfer_count_out  = xfer_q;
  assign stall_count_out = stall_q;
`endif

  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
    !(bus.rden_out && bus.empty_in));
  a_count_range: assert property (@(posedge clk) disable iff (rst)
    count_q <= 2'd2);
  a_data_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.valid_out && !bus.ready_in) |=> $stable(bus.data_out));

endmodule

// File: tb/tb_kanagawa_hal_fifo_stream_reader.sv
// Bench: upstream FIFO and output buffer modelled as queues; every cycle compares rden/valid/occupancy/data.
module tb_kanagawa_hal_fifo_stream_reader;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  kanagawa_hal_fifo_stream_reader_if #(.WIDTH(W)) bus ();

`ifdef KANAGAWA_FIFO_READER_STATS_EN
  logic [31:0] xfer_cnt, stall_cnt;
  logic [3:0]  xfer4, stall4;
  kanagawa_hal_fifo_stream_reader_if #(.WIDTH(W)) bus4 ();
  assign bus4.empty_in = bus.empty_in;
  assign bus4.data_in  = bus.data_in;
  assign bus4.ready_in = bus.ready_in;

  kanagawa_hal_fifo_stream_reader #(.WIDTH(W), .STATS_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .xfer_count_out(xfer_cnt), .stall_count_out(stall_cnt)
  );
  kanagawa_hal_fifo_stream_reader #(.WIDTH(W), .STATS_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4),
    .xfer_count_out(xfer4), .stall_count_out(stall4)
  );
`else
  kanagawa_hal_fifo_stream_reader #(.WIDTH(W), .STATS_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  int checks = 0;
  int failures = 0;

  logic [W-1:0] src[$];      // upstream FIFO contents, head at [0]
  logic [W-1:0] mq[$];       // model of the output buffer
  logic [W-1:0] got[$];      // beats accepted by the consumer
  logic [W-1:0] sent[$];
  int           pop_cyc[$];
  bit           gate = 1'b0; // forces empty_in while upstream has data
  bit           rdy  = 1'b0;
  int           cyc, rden_run, rden_max_run, rden_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    bus.empty_in = (src.size() == 0) || gate;
    bus.data_in  = bus.empty_in ? W'($urandom) : src[0];
    bus.ready_in = rdy;
  endtask

  // One clock: called at a negedge, returns at the next negedge with outputs checked.
  task automatic step();
    bit           m_rden, rd, pp;
    logic [W-1:0] din, dout;
    drive();
    #1;
    m_rden = !rst && !bus.empty_in && (mq.size() < 2);
    chk("rden_out", bus.rden_out, m_rden);
    rd   = bus.rden_out;
    pp   = bus.valid_out && bus.ready_in;
    din  = bus.data_in;
    dout = bus.data_out;
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else begin
      if (pp) begin
        got.push_back(dout);
        pop_cyc.push_back(cyc);
        if (mq.size() != 0) void'(mq.pop_front());
      end
      if (rd) begin
        mq.push_back(din);
        if (src.size() != 0) void'(src.pop_front());
      end
    end
    if (rd) begin
      rden_run++;
      rden_cnt++;
      if (rden_run > rden_max_run) rden_max_run = rden_run;
    end else begin
      rden_run = 0;
    end
    cyc++;
    @(negedge clk);
    chk("valid_out", bus.valid_out, mq.size() != 0);
    chk("occupancy_out", bus.occupancy_out, mq.size());
    if (mq.size() != 0) chk("data_out", bus.data_out, mq[0]);
  endtask

  task automatic clear_stats();
    got.delete();
    pop_cyc.delete();
    cyc = 0;
    rden_run = 0;
    rden_max_run = 0;
    rden_cnt = 0;
  endtask

  initial begin
    int nb, bad;
    drive();
    #1 rst = 1'b1;
    @(negedge clk);

    // Reset held with an empty FIFO
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_valid", bus.valid_out, 1'b0);
      chk("rst_occ", bus.occupancy_out, 2'd0);
    end
    rst = 1'b0;

    // Streaming 0..15 with a always-ready consumer
    clear_stats();
    for (int i = 0; i < 16; i++) src.push_back(W'(i));
    rdy = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("stream_count", got.size(), 16);
    for (int i = 0; i < got.size() && i < 16; i++) chk("stream_order", got[i], i);
    chk("stream_rden_run", rden_max_run, 16);
    if (pop_cyc.size() == 16) begin
      chk("stream_first_cycle", pop_cyc[0], 1);
      chk("stream_last_cycle", pop_cyc[15], 16);
    end else begin
      chk("stream_pop_cycles", pop_cyc.size(), 16);
    end

    // Backpressure: buffer fills to 2 and holds its head
    clear_stats();
    for (int i = 0; i < 8; i++) src.push_back(W'(i));
    rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 1) chk("bp_hold", bus.data_out, 0);
    end
    chk("bp_pops", rden_cnt, 2);
    chk("bp_occ", bus.occupancy_out, 2'd2);
    chk("bp_rden", bus.rden_out, 1'b0);
    rdy = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("bp_count", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++) chk("bp_order", got[i], i);

    // Randomized empty_in (50%) and consumer stalls (25%)
    clear_stats();
    sent.delete();
    nb = 4000;
    for (int i = 0; i < nb; i++) begin
      sent.push_back(W'($urandom));
      src.push_back(sent[i]);
    end
    while (got.size() < nb && cyc < 30000) begin
      gate = ($urandom_range(0, 1) == 1);
      rdy  = ($urandom_range(0, 3) != 0);
      step();
    end
    gate = 1'b0;
    chk("rand_beats", got.size(), nb);
    bad = 0;
    for (int i = 0; i < got.size() && i < nb; i++) if (got[i] !== sent[i]) bad++;
    chk("rand_scoreboard_mismatches", bad, 0);

    // Reset while the buffer is full
    clear_stats();
    for (int i = 0; i < 10; i++) src.push_back(W'(50 + i));
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_occ_before", bus.occupancy_out, 2'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.valid_out, 1'b0);
    chk("mid_rst_occ", bus.occupancy_out, 2'd0);
    chk("mid_rst_rden", bus.rden_out, 1'b0);
    @(negedge clk);
    step();
    rst = 1'b0;
    rdy = 1'b1;
    got.delete();
    for (int i = 0; i < 12; i++) step();
    chk("mid_after_count", got.size(), 8);
    if (got.size() != 0) chk("mid_after_first", got[0], 52);

`ifdef KANAGAWA_FIFO_READER_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) src.push_back(W'(200 + i));
    rdy = 1'b0;
    step();
    for (int i = 0; i < 3; i++) step();
    rdy = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("stats_xfer", xfer_cnt, 10);
    chk("stats_stall", stall_cnt, 3);
    for (int i = 0; i < 10; i++) src.push_back(W'(300 + i));
    for (int i = 0; i < 15; i++) step();
    chk("stats_xfer_20", xfer_cnt, 20);
    chk("stats_xfer_sat4", xfer4, 4'hf);
    chk("stats_stall4", stall4, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
